three_parallel_crc: RTL and testbench
=====================================

Name: three_parallel_crc

Overview:
- 3-way unfolded (3-parallel) CRC generator for g(y) = 1 + y + y^8 + y^9.
- Consumes a 9-bit message 3 bits per clock, MSB first, and produces the 9-bit CRC remainder M(y)·y^9 mod g(y) after 3 cycles.
- Used as a standalone CRC datapath block. The message is held static on data_in for the whole computation.

Parameters:
- POLY, 9'h103, coefficients of g below y^9 (bit i = coefficient of y^i); y^9 is implicit.
- MSG_W, 9, message width in bits; must be a multiple of PAR.
- PAR, 3, bits processed per clock (unfolding factor).
- CRC_W, 9, remainder width (degree of g).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset. Also acts as the start command.
- data_in  input  MSG_W  message; bit MSG_W-1 is transmitted first. Must be held stable from reset until done.
- data_out  output  CRC_W  registered LFSR state. Equals the final CRC once done=1.
- done  output  1  high once all MSG_W/PAR steps are complete.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at posedge clk, reset=1):
  - state r <= 0, data_out = 0.
  - step counter k <= 0.
  - done <= 0.
- Serial reference step for one bit b:
  - fb = b XOR r[8]
  - r' = {r[7:0],0} XOR (fb ? POLY : 0)
- Parallel step, each posedge with reset=0 and k < MSG_W/PAR:
  - Apply the serial step PAR times combinationally.
  - Bits used, in order: data_in[MSG_W-1-PAR·k], then the next lower bit, then the one below that.
  - k <= k+1.
  - Implement as flattened XOR equations (unfolded LFSR), not a clocked bit loop.
- Completion:
  - When k reaches MSG_W/PAR (3), done <= 1 in the same edge as the last update.
  - r is then frozen; further clocks change nothing until the next reset.
- Latency: data_out is valid 3 rising edges after the reset edge.
- Intermediate values of data_out after steps 1 and 2 are architecturally visible and must match the serial model.
- Reset mid-operation: aborts, clears state, restarts on the current data_in.
- Changing data_in while done=0: the result uses whatever bits are present at each step (undefined CRC; no error flag).
- No X-propagation beyond reset: all registers have reset values.

Optional Feature:
- Macro: CRC_SERIAL_CHECK_EN.
- When defined:
  - Adds a bit-serial golden LFSR that shifts 1 bit per clock over MSG_W cycles from reset.
  - Adds output mismatch (1 bit), asserted and held (sticky until reset) if the serial result differs from data_out when both have finished.
- When undefined:
  - No serial logic and no mismatch port.
  - Parallel behaviour is identical either way.

Test Plan:
- data_in=9'b101011010, reset pulse -> data_out 0x00A, then 0x056, then 0x0B6 on edges 1-3; done=1 at edge 3; stays 0x0B6 for 10+ further cycles.
- data_in=9'h100 -> data_out 0x109, 0x141, 0x002; done at edge 3.
- data_in=9'h001 -> data_out 0x000, 0x000, 0x103 (= y^9 mod g).
- data_in=9'h000 -> data_out 0 every cycle; done=1 after 3 edges.
- Reset reasserted after edge 2 of 9'b101011010, data_in changed to 9'h100 -> data_out cleared to 0, then 0x109, 0x141, 0x002.
- CRC_SERIAL_CHECK_EN defined, random 9-bit messages (≥200) -> mismatch stays 0; data_out equals the bit-serial model.

Source files
------------

// File: rtl/three_parallel_crc_if.sv
// Message/result bundle for the 3-parallel CRC block.
// The mismatch signal exists only when CRC_SERIAL_CHECK_EN is defined.
interface three_parallel_crc_if #(
  parameter int MSG_W = 9,
  parameter int CRC_W = 9
);
  // No valid/ready: reset is the start strobe, data_in is held static from
  // the reset edge until done rises, and data_out is final while done=1.
  logic [MSG_W-1:0] data_in;
  logic [CRC_W-1:0] data_out;
  logic             done;
`ifdef CRC_SERIAL_CHECK_EN
  logic             mismatch;

  modport master (output data_in, input data_out, input done, input mismatch);
  modport slave  (input data_in, output data_out, output done, output mismatch);
`else
  modport master (output data_in, input data_out, input done);
  modport slave  (input data_in, output data_out, output done);
`endif
endinterface

// File: rtl/three_parallel_crc.sv
// 3-way unfolded CRC generator for g(y) = 1 + y + y^8 + y^9, MSB first.
// Optional macro CRC_SERIAL_CHECK_EN adds a bit-serial golden LFSR and sticky mismatch flag.
module three_parallel_crc #(
  parameter int               MSG_W = 9,
  parameter int               PAR   = 3,
  parameter int               CRC_W = 9,
  parameter logic [CRC_W-1:0] POLY  = 9'h103
) (
  input  logic                 clk,
  input  logic                 reset,
  three_parallel_crc_if.slave  bus
);

  localparam int               STEPS   = MSG_W / PAR;
  localparam int               K_W     = $clog2(STEPS + 1);
  localparam logic [K_W-1:0]   STEPS_K = K_W'(STEPS);

  // One serial LFSR step; unrolled PAR times below into flat XOR equations.
  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] s,
                                                 input logic             b);
    logic fb;
    fb = b ^ s[CRC_W-1];
    return {s[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  logic [CRC_W-1:0] r;
  logic [CRC_W-1:0] r_next;
  logic [K_W-1:0]   k;
  logic             done_q;
  logic [PAR-1:0]   chunk;

  always_comb begin
    chunk = '0;
    if (k < STEPS_K)
      chunk = PAR'(bus.data_in >> (MSG_W - PAR * (int'(k) + 1)));
    r_next = r;
    for (int i = PAR - 1; i >= 0; i--)
      r_next = lfsr_step(r_next, chunk[i]);
  end

  // Once k hits STEPS the state freezes until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= '0;
      k      <= '0;
      done_q <= 1'b0;
    end else if (k < STEPS_K) begin
      r      <= r_next;
      k      <= k + 1'b1;
      done_q <= (k == STEPS_K - 1'b1);
    end
  end

  assign bus.data_out = r;
  assign bus.done     = done_q;

`ifdef CRC_SERIAL_CHECK_EN
  localparam int             J_W   = $clog2(MSG_W + 1);
  localparam logic [J_W-1:0] MSG_J = J_W'(MSG_W);

  logic [CRC_W-1:0] s_r;
  logic [J_W-1:0]   j;
  logic             ser_bit;
  logic             mismatch_q;

  always_comb begin
    ser_bit = 1'b0;
    if (j < MSG_J)
      ser_bit = 1'(bus.data_in >> (MSG_W - 1 - int'(j)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_r        <= '0;
      j          <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (j < MSG_J) begin
        s_r <= lfsr_step(s_r, ser_bit);
        j   <= j + 1'b1;
      end
      if (j == MSG_J && done_q && s_r != r)
        mismatch_q <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_three_parallel_crc.sv
// Bench for three_parallel_crc: directed vector table, mid-run reset sequence,
// and random messages scored against a polynomial long-division model.
module tb_three_parallel_crc;

  localparam int MSG_W = 9;
  localparam int PAR   = 3;
  localparam int CRC_W = 9;
  localparam int V_W   = MSG_W + CRC_W;
  localparam logic [CRC_W:0] G_FULL = 10'h303;  // y^9 + y^8 + y + 1

  logic clk = 1'b0;
  logic reset = 1'b1;

  three_parallel_crc_if #(.MSG_W(MSG_W), .CRC_W(CRC_W)) bus ();

  three_parallel_crc #(
    .MSG_W(MSG_W), .PAR(PAR), .CRC_W(CRC_W), .POLY(9'h103)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CRC_W-1:0] exp_q[$];

  typedef struct {
    logic [MSG_W-1:0] msg;
    logic [CRC_W-1:0] e1;
    logic [CRC_W-1:0] e2;
    logic [CRC_W-1:0] e3;
  } vec_t;

  vec_t vecs[4];

  // Remainder of (first nbits of msg, MSB first) * y^9 divided by g.
  function automatic logic [CRC_W-1:0] model_crc(input logic [MSG_W-1:0] msg,
                                                 input int nbits);
    logic [V_W-1:0] v;
    v = V_W'(msg >> (MSG_W - nbits)) << CRC_W;
    for (int i = V_W - 1; i >= CRC_W; i--)
      if (v[i]) v = v ^ (V_W'(G_FULL) << (i - CRC_W));
    return v[CRC_W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset edge with msg already on data_in, then release reset.
  task automatic start(input logic [MSG_W-1:0] msg);
    reset = 1'b1;
    bus.data_in = msg;
    tick();
    check("reset_data_out", 32'(bus.data_out), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    reset = 1'b0;
  endtask

  task automatic run_steps(input string tag);
    for (int s = 1; s <= MSG_W / PAR; s++) begin
      tick();
      check({tag, "_data_out"}, 32'(bus.data_out), 32'(exp_q.pop_front()));
      check({tag, "_done"}, 32'(bus.done), 32'(s == MSG_W / PAR));
    end
  endtask

  initial begin
    logic [MSG_W-1:0] msg;
    logic [CRC_W-1:0] final_crc;

    vecs[0] = '{msg: 9'b101011010, e1: 9'h00A, e2: 9'h056, e3: 9'h0B6};
    vecs[1] = '{msg: 9'h100,       e1: 9'h109, e2: 9'h141, e3: 9'h002};
    vecs[2] = '{msg: 9'h001,       e1: 9'h000, e2: 9'h000, e3: 9'h103};
    vecs[3] = '{msg: 9'h000,       e1: 9'h000, e2: 9'h000, e3: 9'h000};

    bus.data_in = '0;
    tick();
    tick();

    // Directed table, each followed by a 10-cycle hold of the final value.
    for (int v = 0; v < 4; v++) begin
      start(vecs[v].msg);
      exp_q.push_back(vecs[v].e1);
      exp_q.push_back(vecs[v].e2);
      exp_q.push_back(vecs[v].e3);
      run_steps("vec");
      repeat (10) tick();
      check("vec_hold_data_out", 32'(bus.data_out), 32'(vecs[v].e3));
      check("vec_hold_done", 32'(bus.done), 32'h1);
`ifdef CRC_SERIAL_CHECK_EN
      check("vec_mismatch", 32'(bus.mismatch), 32'h0);
`endif
    end

    // Reset reasserted after step 2, with a new message presented.
    start(9'b101011010);
    tick();
    check("abort_step1", 32'(bus.data_out), 32'h00A);
    tick();
    check("abort_step2", 32'(bus.data_out), 32'h056);
    start(9'h100);
    exp_q.push_back(9'h109);
    exp_q.push_back(9'h141);
    exp_q.push_back(9'h002);
    run_steps("restart");

    // Random messages against the long-division model.
    for (int n = 0; n < 200; n++) begin
      msg = MSG_W'($urandom_range(0, (1 << MSG_W) - 1));
      start(msg);
      for (int s = 1; s <= MSG_W / PAR; s++)
        exp_q.push_back(model_crc(msg, PAR * s));
      final_crc = model_crc(msg, MSG_W);
      run_steps("rand");
`ifdef CRC_SERIAL_CHECK_EN
      repeat (MSG_W - MSG_W / PAR + 1) tick();
      check("rand_mismatch", 32'(bus.mismatch), 32'h0);
`else
      repeat (2) tick();
`endif
      check("rand_hold", 32'(bus.data_out), 32'(final_crc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
